// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I controller.
//   - RV32I major opcodes recognised by the controller
//   - encodings of the datapath select/control fields driven by multicycle_ctrl
//   - the controller state enumeration
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RS1    = 2'b10,
    SRC_A_ZERO   = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT   = 2'b00,
    RES_MEM_RDATA = 2'b01,
    RES_ALU       = 2'b10
  } result_e;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_LUI      = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

endpackage

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU operation decode shared by the R- and I-type
// execute states.
//   r_type      in  1  1 = register-register op, 0 = register-immediate op
//   funct3      in  3  IR[14:12]
//   funct7_5    in  1  IR[30]
//   alu_control out 4  alu_op_e encoding
module alu_dec
  import ctrl_pkg::*;
(
  input  logic       r_type,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  alu_op_e alu_op_s;

  // For I-type, IR[30] is immediate data except for shifts, so only R-type
  // uses it to pick SUB; any R-type combination not in the ISA decodes to ADD.
  always_comb begin
    alu_op_s = ALU_ADD;
    case (funct3)
      3'b000: if (r_type && funct7_5) alu_op_s = ALU_SUB;  else alu_op_s = ALU_ADD;
      3'b001: if (r_type && funct7_5) alu_op_s = ALU_ADD;  else alu_op_s = ALU_SLL;
      3'b010: if (r_type && funct7_5) alu_op_s = ALU_ADD;  else alu_op_s = ALU_SLT;
      3'b011: if (r_type && funct7_5) alu_op_s = ALU_ADD;  else alu_op_s = ALU_SLTU;
      3'b100: if (r_type && funct7_5) alu_op_s = ALU_ADD;  else alu_op_s = ALU_XOR;
      3'b101: if (funct7_5)           alu_op_s = ALU_SRA;  else alu_op_s = ALU_SRL;
      3'b110: if (r_type && funct7_5) alu_op_s = ALU_ADD;  else alu_op_s = ALU_OR;
      3'b111: if (r_type && funct7_5) alu_op_s = ALU_ADD;  else alu_op_s = ALU_AND;
      default: alu_op_s = ALU_ADD;
    endcase
  end

  assign alu_control = alu_op_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a shared-memory multi-cycle RV32I
// datapath (one ALU, one memory port, IR/old_pc/alu_out registers).
//   inputs : clk, rst_n (async, active low), opcode/funct3/funct7 (IR fields),
//            branch_taken (branch compare), mem_ready (memory handshake)
//   outputs: mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//            alu_src_a, alu_src_b, imm_src, result_src, alu_control,
//            illegal_instr / bus_error (sticky traps), instr_done (retire pulse)
// WAIT_LIMIT bounds the cycles spent waiting on mem_ready (0 = unbounded).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic       instr_done
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             LIMIT_EN = (WAIT_LIMIT != 32'd0);

  state_e           state_r, state_next_s;
  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_inc_s;
  logic             timeout_s, waiting_s;
  logic             set_illegal_s, set_bus_error_s;
  logic             illegal_r, bus_error_r;
  logic [3:0]       dec_alu_s;
  logic             unused_funct7_s;

  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s;
  logic       reg_write_s, instr_done_s;
  src_a_e     alu_src_a_s;
  src_b_e     alu_src_b_s;
  imm_src_e   imm_src_s;
  result_e    result_src_s;
  logic [3:0] alu_control_s;

  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  alu_dec u_alu_dec (
    .r_type      (state_r == ST_EXEC_R),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .alu_control (dec_alu_s)
  );

  // Timeout fires on the edge that would complete the WAIT_LIMIT-th idle cycle.
  assign wait_cnt_inc_s = wait_cnt_r + CNT_ONE;
  assign timeout_s      = LIMIT_EN && !mem_ready && (wait_cnt_inc_s == LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_FETCH;
    else        state_r <= state_next_s;
  end

  // Next-state logic and trap detection.
  always_comb begin
    state_next_s    = state_r;
    set_illegal_s   = 1'b0;
    set_bus_error_s = 1'b0;
    case (state_r)
      ST_FETCH, ST_MEMREAD, ST_MEMWRITE: begin
        if (mem_ready) begin
          if (state_r == ST_FETCH)        state_next_s = ST_DECODE;
          else if (state_r == ST_MEMREAD) state_next_s = ST_MEMWB;
          else                            state_next_s = ST_FETCH;
        end else if (timeout_s) begin
          state_next_s    = ST_TRAP;
          set_bus_error_s = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next_s = ST_MEMADR;
          OP_R:              state_next_s = ST_EXEC_R;
          OP_I:              state_next_s = ST_EXEC_I;
          OP_BRANCH:         state_next_s = ST_BRANCH;
          OP_JAL:            state_next_s = ST_JAL;
          OP_LUI:            state_next_s = ST_LUI;
          default: begin
            state_next_s  = ST_TRAP;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_STORE) state_next_s = ST_MEMWRITE;
        else                    state_next_s = ST_MEMREAD;
      end
      ST_EXEC_R, ST_EXEC_I, ST_JAL, ST_LUI: state_next_s = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH:        state_next_s = ST_FETCH;
      ST_TRAP:                              state_next_s = ST_TRAP;
      default:                              state_next_s = ST_TRAP;
    endcase
  end

  // Counter only advances while stalled in a memory state; leaving or
  // entering one of those states restarts it from zero.
  assign waiting_s = ((state_r == ST_FETCH) || (state_r == ST_MEMREAD) ||
                      (state_r == ST_MEMWRITE)) && (state_next_s == state_r);

  // Memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wait_cnt_r <= {CNT_W{1'b0}};
    else if (waiting_s) wait_cnt_r <= wait_cnt_inc_s;
    else                wait_cnt_r <= {CNT_W{1'b0}};
  end

  // Sticky trap flags; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r   <= 1'b0;
      bus_error_r <= 1'b0;
    end else begin
      illegal_r   <= illegal_r | set_illegal_s;
      bus_error_r <= bus_error_r | set_bus_error_s;
    end
  end

  // Moore output decode; only FETCH, MEMWRITE and BRANCH qualify by inputs.
  always_comb begin
    mem_req_s     = 1'b0;
    mem_write_s   = 1'b0;
    adr_src_s     = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    instr_done_s  = 1'b0;
    alu_src_a_s   = SRC_A_PC;
    alu_src_b_s   = SRC_B_RS2;
    imm_src_s     = IMM_I;
    result_src_s  = RES_ALU_OUT;
    alu_control_s = ALU_ADD;
    case (state_r)
      ST_FETCH: begin
        mem_req_s    = 1'b1;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        alu_src_b_s  = SRC_B_FOUR;
        result_src_s = RES_ALU;
      end
      ST_DECODE: begin
        alu_src_a_s = SRC_A_OLD_PC;
        alu_src_b_s = SRC_B_IMM;
        if (opcode == OP_JAL) imm_src_s = IMM_J;
        else                  imm_src_s = IMM_B;
      end
      ST_MEMADR: begin
        alu_src_a_s = SRC_A_RS1;
        alu_src_b_s = SRC_B_IMM;
        if (opcode == OP_STORE) imm_src_s = IMM_S;
        else                    imm_src_s = IMM_I;
      end
      ST_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
      end
      ST_MEMWB: begin
        result_src_s = RES_MEM_RDATA;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req_s    = 1'b1;
        mem_write_s  = 1'b1;
        adr_src_s    = 1'b1;
        instr_done_s = mem_ready;
      end
      ST_EXEC_R: begin
        alu_src_a_s   = SRC_A_RS1;
        alu_control_s = dec_alu_s;
      end
      ST_EXEC_I: begin
        alu_src_a_s   = SRC_A_RS1;
        alu_src_b_s   = SRC_B_IMM;
        alu_control_s = dec_alu_s;
      end
      ST_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_s   = SRC_A_RS1;
        alu_control_s = ALU_SUB;
        pc_write_s    = branch_taken;
        instr_done_s  = 1'b1;
      end
      ST_JAL: begin
        alu_src_a_s = SRC_A_OLD_PC;
        alu_src_b_s = SRC_B_FOUR;
        pc_write_s  = 1'b1;
      end
      ST_LUI: begin
        alu_src_a_s = SRC_A_ZERO;
        alu_src_b_s = SRC_B_IMM;
        imm_src_s   = IMM_U;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Enables are gated by rst_n so an in-flight request drops immediately.
  assign mem_req       = mem_req_s    & rst_n;
  assign mem_write     = mem_write_s  & rst_n;
  assign ir_write      = ir_write_s   & rst_n;
  assign pc_write      = pc_write_s   & rst_n;
  assign reg_write     = reg_write_s  & rst_n;
  assign instr_done    = instr_done_s & rst_n;
  assign adr_src       = adr_src_s;
  assign alu_src_a     = alu_src_a_s;
  assign alu_src_b     = alu_src_b_s;
  assign imm_src       = imm_src_s;
  assign result_src    = result_src_s;
  assign alu_control   = alu_control_s;
  assign illegal_instr = illegal_r;
  assign bus_error     = bus_error_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Outputs are packed into
// one 20-bit word {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
// instr_done, alu_src_a, alu_src_b, imm_src, result_src, alu_control} and
// compared every cycle against hand-written per-state words.
module tb_multicycle_ctrl;

  localparam logic [19:0] W_FETCH_RDY  = {7'b1001100, 2'b00, 2'b10, 3'b000, 2'b10, 4'b0000};
  localparam logic [19:0] W_FETCH_WAIT = {7'b1000000, 2'b00, 2'b10, 3'b000, 2'b10, 4'b0000};
  localparam logic [19:0] W_DECODE     = {7'b0000000, 2'b01, 2'b01, 3'b010, 2'b00, 4'b0000};
  localparam logic [19:0] W_DECODE_J   = {7'b0000000, 2'b01, 2'b01, 3'b011, 2'b00, 4'b0000};
  localparam logic [19:0] W_ALUWB      = {7'b0000011, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000};
  localparam logic [19:0] W_MEMADR_L   = {7'b0000000, 2'b10, 2'b01, 3'b000, 2'b00, 4'b0000};
  localparam logic [19:0] W_MEMADR_S   = {7'b0000000, 2'b10, 2'b01, 3'b001, 2'b00, 4'b0000};
  localparam logic [19:0] W_MEMREAD    = {7'b1010000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000};
  localparam logic [19:0] W_MEMWB      = {7'b0000011, 2'b00, 2'b00, 3'b000, 2'b01, 4'b0000};
  localparam logic [19:0] W_MEMWR_WAIT = {7'b1110000, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000};
  localparam logic [19:0] W_MEMWR_RDY  = {7'b1110001, 2'b00, 2'b00, 3'b000, 2'b00, 4'b0000};
  localparam logic [19:0] W_BRANCH_T   = {7'b0000101, 2'b10, 2'b00, 3'b000, 2'b00, 4'b0001};
  localparam logic [19:0] W_BRANCH_N   = {7'b0000001, 2'b10, 2'b00, 3'b000, 2'b00, 4'b0001};
  localparam logic [19:0] W_JAL        = {7'b0000100, 2'b01, 2'b10, 3'b000, 2'b00, 4'b0000};
  localparam logic [19:0] W_LUI        = {7'b0000000, 2'b11, 2'b01, 3'b100, 2'b00, 4'b0000};
  localparam logic [19:0] W_TRAP       = 20'h00000;

  logic       clk, rst_n, rst_n2;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       branch_taken, mem_ready, mem_ready2;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal_instr, bus_error, instr_done;
  logic       mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2;
  logic [1:0] alu_src_a2, alu_src_b2, result_src2;
  logic [2:0] imm_src2;
  logic [3:0] alu_control2;
  logic       illegal_instr2, bus_error2, instr_done2;
  logic [19:0] obs;
  int n_vec = 0;
  int n_fail = 0;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done,
                alu_src_a, alu_src_b, imm_src, result_src, alu_control};

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .result_src(result_src), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .instr_done(instr_done)
  );

  multicycle_ctrl #(.WAIT_LIMIT(4)) dut_to (
    .clk(clk), .rst_n(rst_n2), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(mem_ready2), .mem_req(mem_req2),
    .mem_write(mem_write2), .adr_src(adr_src2), .ir_write(ir_write2), .pc_write(pc_write2),
    .reg_write(reg_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .imm_src(imm_src2), .result_src(result_src2), .alu_control(alu_control2),
    .illegal_instr(illegal_instr2), .bus_error(bus_error2), .instr_done(instr_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #1;
    n_vec++;
    if (obs[19:13] !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_enables got %b exp %b", obs[19:13], 7'b0000000);
    end
    n_vec++;
    if ({illegal_instr, bus_error} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags got %b exp %b", {illegal_instr, bus_error}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [19:0] ex [4];
    ex = '{W_FETCH_RDY, W_DECODE, {7'b0, 2'b10, 2'b00, 3'b000, 2'b00, 4'b0000}, W_ALUWB};
    set_ir(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_vec++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL add_c%0d got %h exp %h", i + 1, obs, ex[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [12] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011,
                             7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
    logic [2:0] f3s [12] = '{3'b000, 3'b111, 3'b101, 3'b010, 3'b001, 3'b101,
                             3'b000, 3'b011, 3'b100, 3'b110, 3'b101, 3'b001};
    logic [6:0] f7s [12] = '{7'h20, 7'h00, 7'h20, 7'h00, 7'h20, 7'h20,
                             7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic [3:0] alus [12] = '{4'b0001, 4'b0010, 4'b0111, 4'b1000, 4'b0000, 4'b0111,
                              4'b0000, 4'b1001, 4'b0100, 4'b0011, 4'b0110, 4'b0101};
    logic [1:0] srcb [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [19:0] ex [4];
    for (int e = 0; e < 12; e++) begin
      set_ir(ops[e], f3s[e], f7s[e]);
      ex = '{W_FETCH_RDY, W_DECODE, {7'b0, 2'b10, srcb[e], 3'b000, 2'b00, alus[e]}, W_ALUWB};
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #1;
        n_vec++;
        if (obs !== ex[i]) begin
          n_fail++; $display("FAIL alu_op%0d_c%0d got %h exp %h", e, i + 1, obs, ex[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load();
    logic [19:0] ex [7] = '{W_FETCH_RDY, W_DECODE, W_MEMADR_L, W_MEMREAD, W_MEMREAD, W_MEMREAD, W_MEMWB};
    logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_ir(7'b0000011, 3'b010, 7'b0000000);
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      n_vec++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL load_c%0d got %h exp %h", i + 1, obs, ex[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [19:0] ex [5] = '{W_FETCH_RDY, W_DECODE, W_MEMADR_S, W_MEMWR_WAIT, W_MEMWR_RDY};
    logic        mr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      n_vec++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL store_c%0d got %h exp %h", i + 1, obs, ex[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [19:0] ex [6] = '{W_FETCH_RDY, W_DECODE, W_BRANCH_T, W_FETCH_RDY, W_DECODE, W_BRANCH_N};
    logic        bt [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    set_ir(7'b1100011, 3'b000, 7'b0000000);
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1; branch_taken = bt[i]; #1;
      n_vec++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL branch_c%0d got %h exp %h", i + 1, obs, ex[i]); end
      @(negedge clk);
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_jal_lui();
    logic [19:0] ex [8] = '{W_FETCH_RDY, W_DECODE_J, W_JAL, W_ALUWB, W_FETCH_RDY, W_DECODE, W_LUI, W_ALUWB};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_ir(7'b1101111, 3'b000, 7'b0000000);
      else       set_ir(7'b0110111, 3'b000, 7'b0000000);
      mem_ready = 1'b1; #1;
      n_vec++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL jal_lui_c%0d got %h exp %h", i + 1, obs, ex[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_wait();
    logic [19:0] ex_done [4];
    ex_done = '{W_FETCH_RDY, W_DECODE, {7'b0, 2'b10, 2'b01, 3'b000, 2'b00, 4'b0000}, W_ALUWB};
    set_ir(7'b0010011, 3'b000, 7'b0000000);
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b0; #1;
      n_vec++;
      if (obs !== W_FETCH_WAIT) begin n_fail++; $display("FAIL fetch_wait_c%0d got %h exp %h", i + 1, obs, W_FETCH_WAIT); end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_vec++;
      if (obs !== ex_done[i]) begin n_fail++; $display("FAIL fetch_wait_done_c%0d got %h exp %h", i + 1, obs, ex_done[i]); end
      @(negedge clk);
    end
    n_vec++;
    if (bus_error !== 1'b0) begin n_fail++; $display("FAIL no_timeout_flag got %b exp %b", bus_error, 1'b0); end
  endtask

  task automatic test_illegal();
    set_ir(7'h7F, 3'b000, 7'b0000000);
    mem_ready = 1'b1; #1;
    n_vec++;
    if (obs !== W_FETCH_RDY) begin n_fail++; $display("FAIL illegal_fetch got %h exp %h", obs, W_FETCH_RDY); end
    @(negedge clk); #1;
    n_vec++;
    if ({obs, illegal_instr} !== {W_DECODE, 1'b0}) begin
      n_fail++; $display("FAIL illegal_decode got %h/%b exp %h/0", obs, illegal_instr, W_DECODE);
    end
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      n_vec++;
      if ({obs, illegal_instr} !== {W_TRAP, 1'b1}) begin
        n_fail++; $display("FAIL illegal_trap_c%0d got %h/%b exp %h/1", i, obs, illegal_instr, W_TRAP);
      end
      @(negedge clk);
    end
    rst_n = 1'b0; #1;
    n_vec++;
    if (illegal_instr !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got %b exp %b", illegal_instr, 1'b0); end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_vec++;
    if (obs !== W_FETCH_WAIT) begin n_fail++; $display("FAIL illegal_refetch got %h exp %h", obs, W_FETCH_WAIT); end
    @(negedge clk);
  endtask

  task automatic test_reset_memwrite();
    logic [19:0] ex [4] = '{W_FETCH_RDY, W_DECODE, W_MEMADR_S, W_MEMWR_WAIT};
    logic [19:0] ex2 [4] = '{W_FETCH_RDY, W_DECODE, W_MEMADR_S, W_MEMWR_RDY};
    set_ir(7'b0100011, 3'b010, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3); #1;
      n_vec++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL swrst_c%0d got %h exp %h", i + 1, obs, ex[i]); end
      if (i < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0; #1;
    n_vec++;
    if ({mem_req, mem_write} !== 2'b00) begin
      n_fail++; $display("FAIL swrst_async_drop got %b exp %b", {mem_req, mem_write}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_vec++;
      if (obs !== ex2[i]) begin n_fail++; $display("FAIL swrst_after_c%0d got %h exp %h", i + 1, obs, ex2[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    mem_ready2 = 1'b0;
    rst_n2 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k >= 5) mem_ready2 = 1'b1;
      #1;
      n_vec++;
      if ({mem_req2, bus_error2} !== ((k < 4) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL timeout_k%0d got req/err %b exp %b", k, {mem_req2, bus_error2}, (k < 4) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_n2 = 1'b0;
    opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0;
    branch_taken = 1'b0; mem_ready = 1'b0; mem_ready2 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_jal_lui();
    test_fetch_wait();
    test_illegal();
    test_reset_memwrite();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM controller that sequences a shared-memory, multi-cycle RV32I datapath (one ALU, one memory port, IR/old_pc/alu_out registers).
- Replaces the single-cycle combinational control path.
- Decodes opcode/funct fields once in DECODE, then steps the datapath through per-class states.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeouts.

Parameters:
- WAIT_LIMIT, default 0: maximum cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- CNT_W, default 8: width of the wait counter; WAIT_LIMIT must be < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- branch_taken  in  1  combinational compare result from branch unit for current rs1/rs2/funct3.
- mem_ready  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  store (qualifies mem_req).
- adr_src  out  1  0=PC, 1=alu_out.
- ir_write  out  1  load IR and old_pc.
- pc_write  out  1  load PC from result.
- reg_write  out  1  register file write.
- alu_src_a  out  2  00=PC, 01=old_pc, 10=rs1, 11=zero.
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4.
- imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- result_src  out  2  00=alu_out reg, 01=mem rdata, 10=ALU result.
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- illegal_instr  out  1  sticky trap flag: unsupported opcode.
- bus_error  out  1  sticky trap flag: memory timeout.
- instr_done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Reset:
  - Async reset forces state=FETCH, wait counter=0, illegal_instr=0, bus_error=0.
  - While rst_n=0, mem_req, pc_write, ir_write, reg_write, mem_write and instr_done are forced 0.
  - Reset mid-instruction abandons any in-flight memory request.
- Outputs are Moore-decoded from state. Exceptions: ir_write, pc_write in FETCH, and pc_write in BRANCH are qualified as listed below. Unlisted outputs are 0, alu_control=ADD, imm_src=I.
- FETCH:
  - mem_req=1, adr_src=0, A=PC, B=4, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then DECODE.
- DECODE:
  - A=old_pc, B=imm, imm_src=B (J when opcode is JAL), ADD; target latched in alu_out.
  - Next state by opcode:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - otherwise → TRAP with illegal_instr=1.
- MEMADR: A=rs1, B=imm, imm_src=I for load or S for store. Next state MEMREAD for load, MEMWRITE for store.
- MEMREAD: mem_req=1, adr_src=1; hold until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1; next FETCH.
- MEMWRITE:
  - mem_req=mem_write=1, adr_src=1, held stable until mem_ready=1.
  - On mem_ready: instr_done=1, next FETCH.
- EXEC_R: A=rs1, B=rs2, alu_control from {funct3, funct7[5]}. Unlisted combinations decode to ADD. Next ALUWB.
- EXEC_I:
  - A=rs1, B=imm, alu_control from funct3.
  - funct3=101 uses funct7[5] to select SRA vs SRL.
  - Next ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1; next FETCH.
- BRANCH: A=rs1, B=rs2, SUB, result_src=00, pc_write=branch_taken, instr_done=1; next FETCH.
- JAL:
  - A=old_pc, B=4, ADD, result_src=00, pc_write=1 (target from DECODE).
  - Link value written back in ALUWB.
- LUI: A=zero, B=imm, imm_src=U, ADD; next ALUWB.
- TRAP: absorbing state; all enables 0; exits only via reset.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD and MEMWRITE.
  - Increments each cycle the FSM stays in one of those states with mem_ready=0.
  - If WAIT_LIMIT≠0 and counter reaches WAIT_LIMIT with mem_ready still 0: bus_error=1, next TRAP.
- Latency with zero-wait memory:
  - R, I, LUI, JAL, store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - Each mem_ready=0 cycle adds one.

Decomposition:
- Package ctrl_pkg: opcode localparams; enums alu_op_e, imm_src_e, src_a_e, src_b_e, result_e; state enum state_e (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, TRAP).
- One sub-module alu_dec: combinational mapping of {opcode class, funct3, funct7[5]} to alu_control, shared by EXEC_R and EXEC_I.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 → states FETCH→DECODE→EXEC_R→ALUWB; reg_write=1 in cycle 4 only; alu_control=0000 in EXEC_R; instr_done pulse in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles with mem_req=1 and adr_src=1 stable; MEMWB in cycle 7 with result_src=01.
- beq with branch_taken=1, then a second beq with branch_taken=0 → BRANCH asserts pc_write=1 and pc_write=0 respectively; both return to FETCH after 3 cycles.
- opcode 0x7F → TRAP after DECODE; illegal_instr=1 held for 20 cycles; rst_n pulse clears it and returns to FETCH.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH → bus_error=1 after 4 cycles and state=TRAP.
- Assert rst_n=0 mid-MEMWRITE → mem_req/mem_write drop to 0 asynchronously; FETCH on the first clock after release.
